hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core with ID-stage
// branch resolution. It stalls for load-use, branch-after-ALU and branch-after-load
// dependencies. It freezes the whole pipeline while data memory is busy. It flushes
// IF/ID when a branch is taken.
//
// Optional feature: define HAZARD_STATS_EN to add saturating stall/flush counters.
//
// Ports
//   clk_i            clock, rising edge
//   start_i          asynchronous active-low reset
//   ifid_rs_i/rt_i   source register fields of the instruction in ID
//   ifid_branch_i    instruction in ID is a branch
//   branch_taken_i   ID-stage branch comparator result
//   idex_*_i         MemRead, RegWrite, RegDst, RT and RD fields held in ID/EX
//   dmem_busy_i      data memory not ready; the whole pipeline must hold
//   pc_write_o       PC update enable (combinational)
//   ifid_write_o     IF/ID load enable (combinational)
//   ifid_flush_o     clear IF/ID to NOP on the next edge (combinational)
//   idex_bubble_o    zero all ID/EX control bits on the next edge (combinational)
//   stall_cnt_o      bubble cycles seen, saturating (HAZARD_STATS_EN only)
//   flush_cnt_o      flush cycles seen, saturating (HAZARD_STATS_EN only)
//   state_o          FSM state: RUN=0, STALL=1, FREEZE=2
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        ifid_branch_i,
    input  logic        branch_taken_i,
    input  logic        idex_memread_i,
    input  logic        idex_regwrite_i,
    input  logic        idex_regdst_i,
    input  logic [4:0]  idex_rt_i,
    input  logic [4:0]  idex_rd_i,
    input  logic        dmem_busy_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
`endif
    output logic [1:0]  state_o
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned REM_W = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FREEZE  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;

    logic [REG_W-1:0]   dst;
    logic               match;
    logic               load_use;
    logic               branch_alu;
    logic               branch_load;
    logic               hazard;
    logic [REM_W-1:0]   stall_len;

    // Dependency detection between ID and the instruction sitting in ID/EX
    always_comb begin
        dst         = idex_regdst_i ? idex_rd_i : idex_rt_i;
        match       = (dst != '0) && ((dst == ifid_rs_i) || (dst == ifid_rt_i));
        load_use    = idex_memread_i && (idex_rt_i != '0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        branch_alu  = ifid_branch_i && idex_regwrite_i && !idex_memread_i && match;
        branch_load = ifid_branch_i && load_use;
        hazard      = load_use || branch_alu;
        // The load value is only usable by an ID-stage compare two cycles later
        stall_len   = branch_load ? REM_W'(2) : REM_W'(1);
    end

    // State and remaining-stall counter
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next state and zero-latency pipeline controls
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_busy_i) begin
                    state_d = ST_FREEZE;
                end else if (hazard) begin
                    idex_bubble_o = 1'b1;
                    rem_d         = REM_W'(stall_len - REM_W'(1));
                    state_d       = (rem_d != '0) ? ST_STALL : ST_RUN;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    ifid_flush_o = branch_taken_i && ifid_branch_i;
                end
            end
            ST_STALL: begin
                if (dmem_busy_i) begin
                    state_d = ST_FREEZE;
                end else begin
                    idex_bubble_o = 1'b1;
                    if (rem_q <= REM_W'(1)) begin
                        rem_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        rem_d = REM_W'(rem_q - REM_W'(1));
                    end
                end
            end
            ST_FREEZE: begin
                // The pending stall survives the freeze and resumes afterwards
                if (!dmem_busy_i) begin
                    state_d = (rem_q != '0) ? ST_STALL : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = '0;
            end
        endcase

        // Hold the pipeline while reset is asserted
        if (!start_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_STATS_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (idex_bubble_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= CNT_W'(stall_cnt_q + CNT_W'(1));
            end
            if (ifid_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= CNT_W'(flush_cnt_q + CNT_W'(1));
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each driven cycle pushes the expected
// control vector {pc_write, ifid_write, ifid_flush, idex_bubble, state[1:0]}
// into a scoreboard. A monitor pops it and compares on the falling edge.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic [4:0]  ifid_rs_i;
    logic [4:0]  ifid_rt_i;
    logic        ifid_branch_i;
    logic        branch_taken_i;
    logic        idex_memread_i;
    logic        idex_regwrite_i;
    logic        idex_regdst_i;
    logic [4:0]  idex_rt_i;
    logic [4:0]  idex_rd_i;
    logic        dmem_busy_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic [1:0]  state_o;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
`endif

    hazard_ctrl dut (
        .clk_i           (clk_i),
        .start_i         (start_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_branch_i   (ifid_branch_i),
        .branch_taken_i  (branch_taken_i),
        .idex_memread_i  (idex_memread_i),
        .idex_regwrite_i (idex_regwrite_i),
        .idex_regdst_i   (idex_regdst_i),
        .idex_rt_i       (idex_rt_i),
        .idex_rd_i       (idex_rd_i),
        .dmem_busy_i     (dmem_busy_i),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_bubble_o   (idex_bubble_o),
`ifdef HAZARD_STATS_EN
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
`endif
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected control vectors
    localparam logic [5:0] RUN_OK  = 6'b110000;
    localparam logic [5:0] RUN_FL  = 6'b111000;
    localparam logic [5:0] BUB_RUN = 6'b000100;
    localparam logic [5:0] BUB_STL = 6'b000101;
    localparam logic [5:0] ZER_RUN = 6'b000000;
    localparam logic [5:0] ZER_STL = 6'b000001;
    localparam logic [5:0] ZER_FRZ = 6'b000010;

    typedef struct {
        string       tag;
        logic [5:0]  outs;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_scnt = '0;
    logic [15:0] exp_fcnt = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "/ctl"},
                  32'({pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, state_o}),
                  32'(e.outs));
`ifdef HAZARD_STATS_EN
            check({e.tag, "/stall_cnt"}, 32'(stall_cnt_o), 32'(e.scnt));
            check({e.tag, "/flush_cnt"}, 32'(flush_cnt_o), 32'(e.fcnt));
`endif
        end
    end

    // Drive one cycle of inputs and record what the DUT must show this cycle
    task automatic cyc(input string tag, input logic st,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic tk,
                       input logic mr, input logic rw, input logic rdst,
                       input logic [4:0] xrt, input logic [4:0] xrd,
                       input logic busy, input logic [5:0] exp);
        exp_t e;
        start_i         = st;
        ifid_rs_i       = rs;
        ifid_rt_i       = rt;
        ifid_branch_i   = br;
        branch_taken_i  = tk;
        idex_memread_i  = mr;
        idex_regwrite_i = rw;
        idex_regdst_i   = rdst;
        idex_rt_i       = xrt;
        idex_rd_i       = xrd;
        dmem_busy_i     = busy;
        if (!st) begin
            exp_scnt = '0;
            exp_fcnt = '0;
        end
        e.tag  = tag;
        e.outs = exp;
        e.scnt = exp_scnt;
        e.fcnt = exp_fcnt;
        sb.push_back(e);
        // Counters show the effect of this cycle only after the next edge
        if (st) begin
            if (exp[2]) exp_scnt = 16'(exp_scnt + 16'd1);
            if (exp[3]) exp_fcnt = 16'(exp_fcnt + 16'd1);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        start_i = 1'b0; ifid_rs_i = '0; ifid_rt_i = '0; ifid_branch_i = 1'b0;
        branch_taken_i = 1'b0; idex_memread_i = 1'b0; idex_regwrite_i = 1'b0;
        idex_regdst_i = 1'b0; idex_rt_i = '0; idex_rd_i = '0; dmem_busy_i = 1'b0;
        @(posedge clk_i);
        #1;

        //   tag          st  rs  rt  br tk mr rw dst xrt xrd busy expected
        cyc("reset",      0,  2,  2,  1, 1, 1, 0, 0,  2,  0,  0,   ZER_RUN);
        cyc("idle",       1,  1,  2,  0, 0, 0, 1, 1,  0,  5,  0,   RUN_OK);

        // lw $2 in EX, ID reads $2: one bubble then run
        cyc("lu_bub",     1,  2,  6,  0, 0, 1, 1, 0,  2,  0,  0,   BUB_RUN);
        cyc("lu_after",   1,  2,  6,  0, 0, 0, 0, 0,  0,  0,  0,   RUN_OK);

        // lw $3 in EX, beq rt=$3: two bubbles, one in STALL
        cyc("bl_bub0",    1,  1,  3,  1, 0, 1, 1, 0,  3,  0,  0,   BUB_RUN);
        cyc("bl_bub1",    1,  1,  3,  1, 0, 0, 0, 0,  0,  0,  0,   BUB_STL);
        cyc("bl_taken",   1,  1,  3,  1, 1, 0, 0, 0,  0,  0,  0,   RUN_FL);

        // add $4 in EX (regdst), beq rs=$4 taken: no flush until resolved
        cyc("ba_bub",     1,  4,  8,  1, 1, 0, 1, 1,  9,  4,  0,   BUB_RUN);
        cyc("ba_flush",   1,  4,  8,  1, 1, 0, 0, 0,  0,  0,  0,   RUN_FL);

        // ALU result via rt when regdst=0; non-branch ALU use is forwarded
        cyc("ba_rt",      1, 10,  7,  1, 0, 0, 1, 0,  7,  4,  0,   BUB_RUN);
        cyc("alu_fwd",    1,  7, 10,  0, 0, 0, 1, 0,  7,  4,  0,   RUN_OK);
        cyc("notaken",    1,  7, 10,  1, 0, 0, 0, 0,  0,  0,  0,   RUN_OK);

        // Memory busy for three cycles inside a two-cycle stall
        cyc("fz_bub",     1,  3,  1,  1, 0, 1, 1, 0,  3,  0,  0,   BUB_RUN);
        cyc("fz_busy0",   1,  3,  1,  1, 0, 0, 0, 0,  0,  0,  1,   ZER_STL);
        cyc("fz_busy1",   1,  3,  1,  1, 0, 0, 0, 0,  0,  0,  1,   ZER_FRZ);
        cyc("fz_busy2",   1,  3,  1,  1, 0, 0, 0, 0,  0,  0,  1,   ZER_FRZ);
        cyc("fz_release", 1,  3,  1,  1, 0, 0, 0, 0,  0,  0,  0,   ZER_FRZ);
        cyc("fz_resume",  1,  3,  1,  1, 0, 0, 0, 0,  0,  0,  0,   BUB_STL);
        cyc("fz_run",     1,  3,  1,  1, 0, 0, 0, 0,  0,  0,  0,   RUN_OK);

        // Busy beats a hazard in RUN; the hazard is seen again afterwards
        cyc("bz_hz",      1,  5,  1,  0, 0, 1, 1, 0,  5,  0,  1,   ZER_RUN);
        cyc("bz_frz",     1,  5,  1,  0, 0, 1, 1, 0,  5,  0,  0,   ZER_FRZ);
        cyc("bz_reeval",  1,  5,  1,  0, 0, 1, 1, 0,  5,  0,  0,   BUB_RUN);
        cyc("bz_clear",   1,  5,  1,  0, 0, 0, 0, 0,  0,  0,  0,   RUN_OK);

        // Register $0 never creates a dependency
        cyc("r0_load",    1,  0,  0,  1, 0, 1, 1, 0,  0,  0,  0,   RUN_OK);
        cyc("r0_alu",     1,  0,  0,  1, 1, 0, 1, 1,  0,  0,  0,   RUN_FL);

        // Reset in the middle of a stall abandons it
        cyc("rs_bub",     1,  2,  9,  1, 0, 1, 1, 0,  9,  0,  0,   BUB_RUN);
        cyc("rs_assert",  0,  2,  9,  1, 0, 0, 0, 0,  0,  0,  0,   ZER_RUN);
        cyc("rs_release", 1,  2,  9,  1, 0, 0, 0, 0,  0,  0,  0,   RUN_OK);

        @(negedge clk_i);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
